serial_sub: RTL and testbench
=============================

// Module: serial_sub
//
// PURPOSE
//   Bit-serial unsigned subtractor: computes diff = a - b, LSB first, one bit per clock,
//   using a single half/full-subtractor cell and a borrow flip-flop.
//   Counterpart of the gate-level half adder (sum/carry). It lets the datapath
//   subtract or compare WIDTH-bit operands at single-cell area cost.
//   Driven by a simple start/done handshake from the controlling FSM.
//
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>= 2)
//
// PORTS
//   clk     in   1      single clock, all state on rising edge
//   reset   in   1      synchronous, active-high reset
//   start   in   1      request; sampled only in IDLE or DONE
//   a       in   WIDTH  minuend, captured on accepted start
//   b       in   WIDTH  subtrahend, captured on accepted start
//   busy    out  1      high while in SHIFT
//   done    out  1      one-cycle pulse, diff/borrow valid
//   diff    out  WIDTH  a - b mod 2^WIDTH; held until the next accepted start
//   borrow  out  1      1 when a < b (final borrow-out); held with diff
//
// BEHAVIOUR
//   - Reset (sync, high): state=IDLE; busy=0, done=0, diff=0, borrow=0; counter=0.
//     Reset wins over start on the same edge and aborts any operation in progress.
//   - FSM states: IDLE, SHIFT, DONE.
//     IDLE : start=1 -> load sa<=a, sb<=b, bflop<=0, cnt<=0, go SHIFT.
//     SHIFT: each edge: d=sa[0]^sb[0]^bflop; bout=(~sa[0]&sb[0])|(~(sa[0]^sb[0])&bflop);
//            shift d into diff MSB (diff>>1), sa>>=1, sb>>=1, bflop<=bout, cnt++.
//            After the WIDTH-th shift (cnt==WIDTH-1 on that edge): borrow<=bout, go DONE.
//     DONE : done=1 for exactly this cycle. start=1 -> reload as in IDLE, go SHIFT;
//            otherwise go IDLE.
//   - start is ignored in SHIFT (no queueing, operands not recaptured).
//   - Latency: start accepted on edge E -> done high in the cycle after edge E+WIDTH
//     (WIDTH SHIFT cycles, then 1 DONE cycle). Throughput: one result per WIDTH+1 cycles.
//   - busy=1 exactly in SHIFT. busy and done are never high together.
//   - diff is a working shift register during SHIFT and is not valid until done.
//     It is stable from DONE until the next accepted start.
//   - Counter width: $clog2(WIDTH); no wrap is ever reached (terminates at WIDTH-1).
//   - Arithmetic: unsigned modulo 2^WIDTH; borrow equals (a < b). a==b gives diff=0, borrow=0.
//
// TESTING
//   1 WIDTH=8: a=5, b=3, start 1 cycle -> busy 8 cycles, done pulse, diff=2, borrow=0.
//   2 a=3, b=5 -> diff=254 (0xFE), borrow=1; a=0, b=1 -> diff=255, borrow=1.
//   3 a=255, b=255 and a=0, b=0 -> diff=0, borrow=0; a=255, b=0 -> diff=255, borrow=0.
//   4 start held high with new a/b during SHIFT -> ignored; result matches the first operands;
//     start high in the DONE cycle -> new operation begins with no IDLE cycle.
//   5 reset asserted at SHIFT cycle 4 -> next cycle busy=0, done=0, diff=0, borrow=0, IDLE;
//     a following start completes normally.
//   6 Random sweep, 1000 operand pairs -> {borrow,diff} == {a<b, (a-b)&8'hFF}; done exactly
//     WIDTH+1 cycles after each accepted start.

Source files
------------

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//
// Bit-serial unsigned subtractor. Computes diff = a - b (mod 2^WIDTH), LSB
// first, one bit per clock, through a single full-subtractor cell and one
// borrow flip-flop. The final borrow-out is reported as borrow (1 when a < b).
//
// Ports
//   clk        in   1      single clock, all state on the rising edge
//   reset      in   1      synchronous, active-high; wins over start
//   start      in   1      request; only looked at in IDLE or DONE
//   a          in   WIDTH  minuend, captured when start is accepted
//   b          in   WIDTH  subtrahend, captured when start is accepted
//   busy       out  1      high exactly while the FSM is in SHIFT
//   done       out  1      one-cycle pulse; diff/borrow valid in that cycle
//   diff       out  WIDTH  a - b mod 2^WIDTH, held until the next accepted start
//   borrow     out  1      final borrow-out (a < b), held with diff
//   state_dbg  out  2      current FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: start is a level request, accepted on any rising edge where the
// FSM is in IDLE or DONE. There is no queueing: start seen during SHIFT is
// dropped and the operands are not recaptured. Completion is signalled by a
// single-cycle done pulse exactly WIDTH+1 cycles after the accepting edge;
// holding start high through that DONE cycle begins the next operation with
// no intervening IDLE cycle.
// -----------------------------------------------------------------------------
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic [1:0]       state_dbg
);

   // The counter only ever needs to reach WIDTH-1, so $clog2(WIDTH) bits
   // are enough and it never wraps.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] sa_q;      // remaining minuend bits, LSB is current bit
   logic [WIDTH-1:0] sb_q;      // remaining subtrahend bits
   logic             bflop_q;   // borrow carried between bit positions
   logic [CW-1:0]    cnt_q;     // index of the bit being processed
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;

   // Full-subtractor cell outputs for the current bit position.
   logic             cell_d;
   logic             cell_bout;
   logic             accept;
   logic             last_bit;

   // ---------------------------------------------------------------------
   // Subtractor cell: d = x ^ y ^ bin,
   // bout = (~x & y) | (~(x ^ y) & bin)
   // ---------------------------------------------------------------------
   always_comb begin
      cell_d    = sa_q[0] ^ sb_q[0] ^ bflop_q;
      cell_bout = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bflop_q);
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      last_bit = (cnt_q == LAST_CNT);

      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Back-to-back: a start seen in DONE goes straight to SHIFT.
            if (start) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath
   //
   // diff is used as the result shift register: each new bit enters at the
   // MSB, so after WIDTH shifts bit 0 of the result sits in diff[0]. It is
   // not cleared on accept, so the previous result stays visible until the
   // first shift of the new operation.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sa_q     <= '0;
         sb_q     <= '0;
         bflop_q  <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else if (accept) begin
         sa_q    <= a;
         sb_q    <= b;
         bflop_q <= 1'b0;
         cnt_q   <= '0;
      end else if (state_q == SHIFT) begin
         diff_q  <= {cell_d, diff_q[WIDTH-1:1]};
         sa_q    <= sa_q >> 1;
         sb_q    <= sb_q >> 1;
         bflop_q <= cell_bout;
         if (last_bit) begin
            // Borrow out of the MSB is the a < b flag.
            borrow_q <= cell_bout;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs (decoded from registered state, so glitch-free relative to clk)
   // ---------------------------------------------------------------------
   always_comb begin
      busy      = (state_q == SHIFT);
      done      = (state_q == DONE);
      diff      = diff_q;
      borrow    = borrow_q;
      state_dbg = state_q;
   end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

   localparam int WIDTH = 8;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic [1:0]       state_dbg;

   int errors;
   int checks;

   serial_sub #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .borrow    (borrow),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reset ----------------
   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      step();
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %0b expected 0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done: got %0b expected 0", done);
      end
      checks++;
      if (diff !== 8'h00) begin
         errors++;
         $display("FAIL reset_diff: got %0h expected 0", diff);
      end
      checks++;
      if (borrow !== 1'b0) begin
         errors++;
         $display("FAIL reset_borrow: got %0b expected 0", borrow);
      end
      checks++;
      if (state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", state_dbg);
      end
      reset = 1'b0;
      step();
   endtask

   // One full operation: start for one cycle, busy for WIDTH cycles, then a
   // done pulse carrying the expected result, then back to idle.
   task automatic run_op(input string name, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb,
                         input logic [WIDTH-1:0] exp_diff,
                         input logic exp_borrow);
      start = 1'b1;
      a     = va;
      b     = vb;
      step();                       // accepting edge E
      start = 1'b0;
      a     = ~va;                  // operands must already be captured
      b     = ~vb;
      for (int i = 0; i < WIDTH; i++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_cycle%0d: got busy=%0b done=%0b expected busy=1 done=0",
                     name, i, busy, done);
         end
         step();
      end
      // now just past edge E+WIDTH: the DONE cycle
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || state_dbg !== 2'd2) begin
         errors++;
         $display("FAIL %s_done: got done=%0b busy=%0b state=%0d expected done=1 busy=0 state=2",
                  name, done, busy, state_dbg);
      end
      checks++;
      if (diff !== exp_diff) begin
         errors++;
         $display("FAIL %s_diff: a=%0d b=%0d got %0d expected %0d", name, va, vb, diff, exp_diff);
      end
      checks++;
      if (borrow !== exp_borrow) begin
         errors++;
         $display("FAIL %s_borrow: a=%0d b=%0d got %0b expected %0b", name, va, vb, borrow,
                  exp_borrow);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL %s_idle: got done=%0b busy=%0b state=%0d expected 0 0 0",
                  name, done, busy, state_dbg);
      end
      checks++;
      if (diff !== exp_diff || borrow !== exp_borrow) begin
         errors++;
         $display("FAIL %s_hold: got diff=%0d borrow=%0b expected %0d %0b",
                  name, diff, borrow, exp_diff, exp_borrow);
      end
   endtask

   task automatic test_basic();
      run_op("basic_5_3", 8'd5, 8'd3, 8'd2, 1'b0);
   endtask

   task automatic test_borrow();
      run_op("borrow_3_5", 8'd3, 8'd5, 8'hFE, 1'b1);
      run_op("borrow_0_1", 8'd0, 8'd1, 8'hFF, 1'b1);
   endtask

   task automatic test_equal_edges();
      run_op("eq_255_255", 8'd255, 8'd255, 8'd0, 1'b0);
      run_op("eq_0_0", 8'd0, 8'd0, 8'd0, 1'b0);
      run_op("max_255_0", 8'd255, 8'd0, 8'd255, 1'b0);
   endtask

   // start held through SHIFT with different operands is ignored; still
   // high in DONE it launches the next operation with no IDLE cycle.
   task automatic test_back_to_back();
      start = 1'b1;
      a     = 8'd10;
      b     = 8'd4;
      step();                       // accept (10,4)
      a     = 8'd200;
      b     = 8'd100;
      for (int i = 0; i < WIDTH; i++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy_cycle%0d: got %0b expected 1", i, busy);
         end
         step();
      end
      checks++;
      if (done !== 1'b1 || diff !== 8'd6 || borrow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: got done=%0b diff=%0d borrow=%0b expected 1 6 0",
                  done, diff, borrow);
      end
      step();                       // accept (200,100) directly from DONE
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || state_dbg !== 2'd1) begin
         errors++;
         $display("FAIL b2b_no_idle: got busy=%0b done=%0b state=%0d expected 1 0 1",
                  busy, done, state_dbg);
      end
      for (int i = 0; i < WIDTH; i++) step();
      checks++;
      if (done !== 1'b1 || diff !== 8'd100 || borrow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: got done=%0b diff=%0d borrow=%0b expected 1 100 0",
                  done, diff, borrow);
      end
      step();
   endtask

   // Reset in the middle of SHIFT aborts and clears everything.
   task automatic test_reset_mid();
      run_op("pre_abort", 8'd1, 8'd2, 8'hFF, 1'b1);
      start = 1'b1;
      a     = 8'd50;
      b     = 8'd20;
      step();                       // accept
      start = 1'b0;
      step();
      step();
      step();                       // three shifts done
      reset = 1'b1;
      step();                       // reset edge during the fourth SHIFT cycle
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL abort_state: got busy=%0b done=%0b state=%0d expected 0 0 0",
                  busy, done, state_dbg);
      end
      checks++;
      if (diff !== 8'd0 || borrow !== 1'b0) begin
         errors++;
         $display("FAIL abort_clear: got diff=%0d borrow=%0b expected 0 0", diff, borrow);
      end
      reset = 1'b0;
      step();
      run_op("post_abort", 8'd50, 8'd20, 8'd30, 1'b0);
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [WIDTH-1:0] ed;
      logic             eb;
      for (int n = 0; n < 1000; n++) begin
         ra = WIDTH'($urandom_range(0, 255));
         rb = WIDTH'($urandom_range(0, 255));
         ed = ra - rb;
         eb = (ra < rb);
         run_op("random", ra, rb, ed, eb);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_basic();
      test_borrow();
      test_equal_edges();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
